// File: rtl/dma_rc_arb_pkg.sv
// Shared types and defaults for the RC completion packet arbiter.
// Packet counters are built only when DMA_RC_PKT_ARB_CNT_EN is defined.
package dma_rc_arb_pkg;

  localparam int unsigned RC_DATA_WIDTH  = 512;
  localparam int unsigned RC_USER_WIDTH  = 161;
  localparam int unsigned RC_KEEP_WIDTH  = RC_DATA_WIDTH / 32;
  localparam int unsigned RC_READY_WIDTH = 22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [RC_DATA_WIDTH-1:0] tdata;
    logic                     tlast;
    logic [RC_USER_WIDTH-1:0] tuser;
    logic [RC_KEEP_WIDTH-1:0] tkeep;
  } rc_beat_t;

  // One-hot round-robin pick; last=1 means source 1 was granted most recently.
  function automatic logic [1:0] rr_pick(input logic v0, input logic v1, input logic last);
    logic [1:0] pick;
    pick = 2'b00;
    if (v0 && v1)  pick = last ? 2'b01 : 2'b10;
    else if (v0)   pick = 2'b01;
    else if (v1)   pick = 2'b10;
    return pick;
  endfunction

endpackage

// File: rtl/dma_rc_skid_buf.sv
// Two-entry skid buffer; the head entry drives the outputs directly and
// in_ready_c is decoded from registered occupancy only.
module dma_rc_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready_c,
  output logic             active,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] d1_q;
  logic             v1_q;
  logic             push_c;
  logic             pop_c;

  assign in_ready_c = active & ~v1_q;
  assign push_c     = in_valid & in_ready_c;
  assign pop_c      = out_valid & out_ready;

  // active holds ready low through reset and for the first cycle after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active    <= 1'b0;
      out_valid <= 1'b0;
      v1_q      <= 1'b0;
    end else begin
      active <= 1'b1;
      if (push_c && !pop_c) begin
        if (out_valid) v1_q <= 1'b1;
        out_valid <= 1'b1;
      end else if (pop_c && !push_c) begin
        out_valid <= v1_q;
        v1_q      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_c && !pop_c) begin
      if (out_valid) d1_q     <= in_data;
      else           out_data <= in_data;
    end else if (pop_c && !push_c) begin
      out_data <= d1_q;
    end else if (push_c && pop_c) begin
      if (v1_q) begin
        out_data <= d1_q;
        d1_q     <= in_data;
      end else begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/dma_rc_pkt_arb.sv
// Packet-granular round-robin merge of two RC completion streams.
// Define DMA_RC_PKT_ARB_CNT_EN to build the per-source packet counters.
module dma_rc_pkt_arb
  import dma_rc_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = RC_DATA_WIDTH,
  parameter int unsigned USER_WIDTH  = RC_USER_WIDTH,
  parameter int unsigned READY_WIDTH = RC_READY_WIDTH
) (
  input  logic                       user_clk,
  input  logic                       user_reset,
  input  logic [DATA_WIDTH-1:0]      s0_tdata,
  input  logic                       s0_tlast,
  input  logic [USER_WIDTH-1:0]      s0_tuser,
  input  logic [DATA_WIDTH/32-1:0]   s0_tkeep,
  input  logic                       s0_tvalid,
  output logic [READY_WIDTH-1:0]     s0_tready,
  input  logic [DATA_WIDTH-1:0]      s1_tdata,
  input  logic                       s1_tlast,
  input  logic [USER_WIDTH-1:0]      s1_tuser,
  input  logic [DATA_WIDTH/32-1:0]   s1_tkeep,
  input  logic                       s1_tvalid,
  output logic [READY_WIDTH-1:0]     s1_tready,
  output logic [DATA_WIDTH-1:0]      m_tdata,
  output logic                       m_tlast,
  output logic [USER_WIDTH-1:0]      m_tuser,
  output logic [DATA_WIDTH/32-1:0]   m_tkeep,
  output logic                       m_tvalid,
  input  logic [READY_WIDTH-1:0]     m_tready,
  output logic [31:0]                pkt_cnt0,
  output logic [31:0]                pkt_cnt1,
  output logic [1:0]                 grant
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 32;
  localparam int unsigned BEAT_WIDTH = DATA_WIDTH + 1 + USER_WIDTH + KEEP_WIDTH;

  arb_state_e            state_q, state_d;
  logic                  last_q, last_d;
  logic [1:0]            own;
  logic                  sel_valid;
  logic                  sel_last;
  logic                  fire;
  logic                  in_ready_c;
  logic                  skid_active;
  logic [BEAT_WIDTH-1:0] sel_beat;
  logic [BEAT_WIDTH-1:0] out_beat;
  logic                  unused_tready;

  assign unused_tready = ^m_tready[READY_WIDTH-1:1];

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // IDLE grants in the same cycle; a finishing packet hands straight to a waiting peer
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    own       = 2'b00;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    fire      = 1'b0;
    unique case (state_q)
      IDLE:    own = rr_pick(s0_tvalid, s1_tvalid, last_q);
      OWN0:    own = 2'b01;
      OWN1:    own = 2'b10;
      default: own = 2'b00;
    endcase
    sel_valid = (own[0] & s0_tvalid) | (own[1] & s1_tvalid);
    sel_last  = own[1] ? s1_tlast : s0_tlast;
    fire      = sel_valid & in_ready_c;
    if (fire) begin
      if (state_q == IDLE) last_d = own[1];
      if (sel_last) begin
        if (own[0] && s1_tvalid) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end else if (own[1] && s0_tvalid) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end else begin
        state_d = own[1] ? OWN1 : OWN0;
      end
    end
  end

  assign sel_beat  = own[1] ? {s1_tdata, s1_tlast, s1_tuser, s1_tkeep}
                            : {s0_tdata, s0_tlast, s0_tuser, s0_tkeep};
  assign s0_tready = {READY_WIDTH{own[0] & in_ready_c}};
  assign s1_tready = {READY_WIDTH{own[1] & in_ready_c}};
  assign grant     = own & {2{skid_active}};

  dma_rc_skid_buf #(
    .WIDTH(BEAT_WIDTH)
  ) u_skid (
    .clk        (user_clk),
    .rst        (user_reset),
    .in_data    (sel_beat),
    .in_valid   (sel_valid),
    .in_ready_c (in_ready_c),
    .active     (skid_active),
    .out_data   (out_beat),
    .out_valid  (m_tvalid),
    .out_ready  (m_tready[0])
  );

  assign {m_tdata, m_tlast, m_tuser, m_tkeep} = out_beat;

`ifdef DMA_RC_PKT_ARB_CNT_EN
  // Counters advance on the accepted tlast beat and wrap naturally
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      pkt_cnt0 <= 32'd0;
      pkt_cnt1 <= 32'd0;
    end else if (fire && sel_last) begin
      if (own[0]) pkt_cnt0 <= pkt_cnt0 + 32'd1;
      if (own[1]) pkt_cnt1 <= pkt_cnt1 + 32'd1;
    end
  end
`else
  assign pkt_cnt0 = 32'd0;
  assign pkt_cnt1 = 32'd0;
`endif

endmodule
